// File: rtl/pwm_source.sv
// Complementary PWM source: free-running period counter against a double-buffered
// duty register; duty writes land in a pending slot and apply only on a period wrap.
module pwm_source #(
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] duty,
   input  logic             duty_vld,
   output logic             duty_rdy,
   output logic             pwm_high,
   output logic             pwm_low,
   output logic             pwm_synch
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_duty_pend;
   logic [WIDTH-1:0] r_duty_act;
   logic             r_pend_full;
   logic             r_pwm_high;
   logic             r_pwm_low;
   logic             r_pwm_synch;

   logic             w_wrap;
   logic             w_below;
   logic             w_accept;
   logic             w_transfer;

   assign w_wrap     = (r_cnt == '1);
   assign w_below    = (r_cnt < r_duty_act);
   assign w_accept   = duty_vld & ~r_pend_full;
   // While disabled the pending value is promoted at once, so the first period
   // after enable already uses the latest duty.
   assign w_transfer = r_pend_full & (~en | w_wrap);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_duty_pend <= '0;
         r_duty_act  <= '0;
         r_pend_full <= 1'b0;
         r_pwm_high  <= 1'b0;
         r_pwm_low   <= 1'b0;
         r_pwm_synch <= 1'b0;
      end else begin
         r_cnt <= en ? r_cnt + 1'b1 : '0;

         // Accept and transfer are exclusive: accept needs the slot empty,
         // transfer needs it full.
         if (w_transfer) begin
            r_duty_act  <= r_duty_pend;
            r_pend_full <= 1'b0;
         end else if (w_accept) begin
            r_duty_pend <= duty;
            r_pend_full <= 1'b1;
         end

         r_pwm_high  <= en & w_below;
         r_pwm_low   <= en & ~w_below;
         r_pwm_synch <= en & w_wrap;
      end
   end

   assign duty_rdy  = ~r_pend_full;
   assign pwm_high  = r_pwm_high;
   assign pwm_low   = r_pwm_low;
   assign pwm_synch = r_pwm_synch;

endmodule

// File: tb/tb_pwm_source.sv
// Directed bench for pwm_source at WIDTH = 11: reset/idle, duty extremes,
// double buffering, wrap-cycle write collision and asynchronous reset.
module tb_pwm_source;

   localparam int unsigned W   = 11;
   localparam int          PER = 2048;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [W-1:0] duty;
   logic         duty_vld;
   logic         duty_rdy;
   logic         pwm_high;
   logic         pwm_low;
   logic         pwm_synch;

   int n_checks;
   int n_errors;

   pwm_source #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .duty      (duty),
      .duty_vld  (duty_vld),
      .duty_rdy  (duty_rdy),
      .pwm_high  (pwm_high),
      .pwm_low   (pwm_low),
      .pwm_synch (pwm_synch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge; inputs are driven and outputs sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one full period. Sample i follows the edge that saw cnt == i.
   // Optional one-cycle write pulses are raised after samples wr_idx / wr2_idx.
   task automatic run_period(input int wr_idx, input logic [W-1:0] wr_val,
                             input int wr2_idx, input logic [W-1:0] wr2_val,
                             output int hi, output int lo, output int sy,
                             output int sy_pos, output int both,
                             output logic rdy_wrap, output logic rdy_after);
      hi = 0; lo = 0; sy = 0; sy_pos = -1; both = 0;
      rdy_wrap = 1'bx; rdy_after = 1'bx;
      for (int i = 0; i < PER; i++) begin
         tick();
         if (pwm_high) hi++;
         if (pwm_low) lo++;
         if (pwm_high && pwm_low) both++;
         if (pwm_synch) begin
            sy++;
            sy_pos = i;
         end
         if (i == PER - 2) rdy_wrap = duty_rdy;
         if (i == PER - 1) rdy_after = duty_rdy;
         duty_vld = 1'b0;
         if (i == wr_idx) begin
            duty_vld = 1'b1;
            duty     = wr_val;
         end else if (i == wr2_idx) begin
            duty_vld = 1'b1;
            duty     = wr2_val;
         end
      end
   endtask

   int   hi, lo, sy, sy_pos, both;
   logic rdy_w, rdy_a;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      duty     = '0;
      duty_vld = 1'b0;

      // Reset held, then idle with en = 0
      repeat (3) tick();
      check_val("rst_outs", {29'd0, pwm_high, pwm_low, pwm_synch}, 32'd0);
      check_val("rst_rdy", {31'd0, duty_rdy}, 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("idle", {28'd0, pwm_high, pwm_low, pwm_synch, duty_rdy}, 32'd1);
      end

      // Load 512 while disabled: pending, then promoted on the next edge
      duty = 11'd512; duty_vld = 1'b1;
      tick();
      duty_vld = 1'b0;
      check_val("rdy_after_wr", {31'd0, duty_rdy}, 32'd0);
      tick();
      check_val("rdy_after_xfer", {31'd0, duty_rdy}, 32'd1);

      // Period 1 after enable: duty 512, first synch 2048 cycles after en rise
      en = 1'b1;
      run_period(-1, '0, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("p1_high", hi, 512);
      check_val("p1_low", lo, 1536);
      check_val("p1_synch_cnt", sy, 1);
      check_val("p1_synch_pos", sy_pos, PER - 1);
      check_val("p1_overlap", both, 0);

      // Period 2: write 1024 mid-period, second write 50 must be ignored
      run_period(100, 11'd1024, 500, 11'd50, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("p2_high", hi, 512);
      check_val("p2_low", lo, 1536);
      check_val("p2_rdy_wrap", {31'd0, rdy_w}, 32'd0);
      check_val("p2_rdy_after", {31'd0, rdy_a}, 32'd1);
      check_val("p2_synch_pos", sy_pos, PER - 1);

      // Period 3: duty 1024; write 300 in the cnt == 2047 cycle
      run_period(PER - 2, 11'd300, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("p3_high", hi, 1024);
      check_val("p3_low", lo, 1024);
      check_val("p3_rdy_wrap", {31'd0, rdy_w}, 32'd1);
      check_val("p3_rdy_after", {31'd0, rdy_a}, 32'd0);

      // Period 4: still 1024, 300 applies at this wrap
      run_period(-1, '0, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("p4_high", hi, 1024);
      check_val("p4_rdy_wrap", {31'd0, rdy_w}, 32'd0);
      check_val("p4_rdy_after", {31'd0, rdy_a}, 32'd1);

      // Period 5: duty 300; queue maximum duty
      run_period(10, 11'd2047, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("p5_high", hi, 300);
      check_val("p5_low", lo, 1748);

      // Period 6: duty 2047; queue zero duty
      run_period(10, 11'd0, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("max_high", hi, 2047);
      check_val("max_low", lo, 1);
      check_val("max_overlap", both, 0);
      check_val("max_synch", sy, 1);

      // Period 7: duty 0
      run_period(-1, '0, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("zero_high", hi, 0);
      check_val("zero_low", lo, 2048);

      // Enable fall: outputs off on the first edge sampling en = 0
      en = 1'b0;
      tick();
      check_val("en_fall", {29'd0, pwm_high, pwm_low, pwm_synch}, 32'd0);

      // Async reset mid-period with duty 1000 and a write still pending
      duty = 11'd1000; duty_vld = 1'b1;
      tick();
      duty_vld = 1'b0;
      tick();
      en = 1'b1;
      for (int i = 0; i < 700; i++) begin
         tick();
         duty_vld = (i == 600);
         duty     = 11'd77;
      end
      duty_vld = 1'b0;
      check_val("pre_rst_high", {31'd0, pwm_high}, 32'd1);
      check_val("pre_rst_rdy", {31'd0, duty_rdy}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_outs", {29'd0, pwm_high, pwm_low, pwm_synch}, 32'd0);
      check_val("async_rst_rdy", {31'd0, duty_rdy}, 32'd1);
      en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // After re-enable duty_act is 0 and the discarded 77 never appears
      en = 1'b1;
      run_period(-1, '0, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("post_rst_high", hi, 0);
      check_val("post_rst_low", lo, 2048);
      run_period(-1, '0, -1, '0, hi, lo, sy, sy_pos, both, rdy_w, rdy_a);
      check_val("post_rst_high2", hi, 0);
      check_val("post_rst_synch", sy, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
